// File: rtl/hard_coded_weight.sv
// hard_coded_weight: per-class clause weight bank for the class-sum adder array.
// Holds CLASS_NUM x CLAUSE_NUM signed 14-bit weights, all visible in parallel.
// Reset and reload restore a fixed pattern; a single-entry port overrides entries.
// Optional build macro HCW_WR_CLAMP_EN: clamp written values to +/-MAX_MAG and
// add the wr_clamped pulse output.
module hard_coded_weight #(
   parameter int CLAUSE_NUM = 100,
   parameter int CLASS_NUM  = 10,
   parameter int MAX_MAG    = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  reload,
   input  logic                                  wr_en,
   input  logic [$clog2(CLASS_NUM)-1:0]          wr_class,
   input  logic [$clog2(CLAUSE_NUM)-1:0]         wr_clause,
   input  logic signed [13:0]                    wr_data,
`ifdef HCW_WR_CLAMP_EN
   output logic                                  wr_clamped,
`endif
   output logic                                  wr_err,
   output logic signed [13:0]                    weights [CLASS_NUM][CLAUSE_NUM]
);

   localparam int unsigned N_CLASS  = CLASS_NUM;
   localparam int unsigned N_CLAUSE = CLAUSE_NUM;
   localparam int unsigned MAG_U    = MAX_MAG;

   // Fixed pattern: magnitude 1 + ((3c + 5k) mod MAX_MAG), negative when c+k is odd.
   // Only ever called with unrolled loop indices, so it folds to constants.
   function automatic logic signed [13:0] def_weight(input int unsigned c,
                                                     input int unsigned k);
      logic signed [13:0] mag;
      mag = 14'(1 + ((3 * c + 5 * k) % MAG_U));
      return (((c + k) % 2) == 0) ? mag : -mag;
   endfunction

   logic               addr_ok;
   logic               wr_hit;
   logic               wr_bad;
   logic signed [13:0] store_val;
`ifdef HCW_WR_CLAMP_EN
   localparam logic signed [13:0] MAG_POS = 14'(MAX_MAG);
   localparam logic signed [13:0] MAG_NEG = -MAG_POS;
   logic               clamp_hit;
`endif

   // Decode the write request and form the value to be stored.
   always_comb begin
      addr_ok   = (int'(wr_class) < CLASS_NUM) && (int'(wr_clause) < CLAUSE_NUM);
      wr_hit    = !reload && wr_en && addr_ok;
      wr_bad    = !reload && wr_en && !addr_ok;
      store_val = wr_data;
`ifdef HCW_WR_CLAMP_EN
      clamp_hit = 1'b0;
      if (wr_data > MAG_POS) begin
         store_val = MAG_POS;
         clamp_hit = 1'b1;
      end else if (wr_data < MAG_NEG) begin
         store_val = MAG_NEG;
         clamp_hit = 1'b1;
      end
`endif
   end

   // Weight storage: reset/reload restore the pattern, otherwise single-entry write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned c = 0; c < N_CLASS; c++) begin
            for (int unsigned k = 0; k < N_CLAUSE; k++) begin
               weights[c][k] <= def_weight(c, k);
            end
         end
      end else if (reload) begin
         for (int unsigned c = 0; c < N_CLASS; c++) begin
            for (int unsigned k = 0; k < N_CLAUSE; k++) begin
               weights[c][k] <= def_weight(c, k);
            end
         end
      end else if (wr_hit) begin
         weights[wr_class][wr_clause] <= store_val;
      end
   end

   // Status pulses, valid for the single cycle after the offending write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err <= 1'b0;
`ifdef HCW_WR_CLAMP_EN
         wr_clamped <= 1'b0;
`endif
      end else begin
         wr_err <= wr_bad;
`ifdef HCW_WR_CLAMP_EN
         wr_clamped <= wr_hit && clamp_hit;
`endif
      end
   end

endmodule

// File: tb/tb_hard_coded_weight.sv
// tb_hard_coded_weight: directed and randomized checks of hard_coded_weight
// against an array-based reference model of the weight bank.
module tb_hard_coded_weight;

   localparam int NCLS = 10;
   localparam int NCL  = 100;
   localparam int MAG  = 64;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               reload = 1'b0;
   logic               wr_en = 1'b0;
   logic [3:0]         wr_class = '0;
   logic [6:0]         wr_clause = '0;
   logic signed [13:0] wr_data = '0;
   logic               wr_err;
   logic signed [13:0] weights [NCLS][NCL];
`ifdef HCW_WR_CLAMP_EN
   logic               wr_clamped;
   int                 exp_clamp = 0;
`endif

   int model [NCLS][NCL];
   int exp_err = 0;
   int errors = 0;
   int checks = 0;

   hard_coded_weight #(.CLAUSE_NUM(NCL), .CLASS_NUM(NCLS), .MAX_MAG(MAG)) dut (
      .clk       (clk),
      .rst       (rst),
      .reload    (reload),
      .wr_en     (wr_en),
      .wr_class  (wr_class),
      .wr_clause (wr_clause),
      .wr_data   (wr_data),
`ifdef HCW_WR_CLAMP_EN
      .wr_clamped(wr_clamped),
`endif
      .wr_err    (wr_err),
      .weights   (weights)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int def_val(input int c, input int k);
      int m;
      m = 1 + ((3 * c + 5 * k) % MAG);
      return ((c + k) % 2 == 0) ? m : -m;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCLS; c++)
         for (int k = 0; k < NCL; k++)
            model[c][k] = def_val(c, k);
      exp_err = 0;
`ifdef HCW_WR_CLAMP_EN
      exp_clamp = 0;
`endif
   endfunction

   function automatic int count_diffs();
      int n = 0;
      for (int c = 0; c < NCLS; c++)
         for (int k = 0; k < NCL; k++)
            if (int'(weights[c][k]) != model[c][k]) n++;
      return n;
   endfunction

   // Apply one clocked operation, then advance the model to the post-edge state.
   task automatic cycle(input bit rl, input bit we, input int cls, input int cl, input int d);
      int v;
      reload    = rl;
      wr_en     = we;
      wr_class  = 4'(cls);
      wr_clause = 7'(cl);
      wr_data   = 14'(d);
      @(posedge clk);
      #1;
      exp_err = 0;
`ifdef HCW_WR_CLAMP_EN
      exp_clamp = 0;
`endif
      if (rl) begin
         model_reset();
      end else if (we) begin
         if (cls < NCLS && cl < NCL) begin
            v = d;
`ifdef HCW_WR_CLAMP_EN
            if (v > MAG) begin v = MAG; exp_clamp = 1; end
            else if (v < -MAG) begin v = -MAG; exp_clamp = 1; end
`endif
            model[cls][cl] = v;
         end else begin
            exp_err = 1;
         end
      end
      reload = 1'b0;
      wr_en  = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_array"}, count_diffs(), 0);
      check({tag, "_err"}, int'(wr_err), exp_err);
`ifdef HCW_WR_CLAMP_EN
      check({tag, "_clamped"}, int'(wr_clamped), exp_clamp);
`endif
   endtask

   initial begin
      int cls, cl, d;
      bit rl, we;

      // Asynchronous reset with no clock edge involved.
      #2 rst = 1'b0;
      #2;
      model_reset();
      check("rst_w00", int'(weights[0][0]), 1);
      check("rst_w10", int'(weights[1][0]), -4);
      check("rst_w23", int'(weights[2][3]), -22);
      check("rst_w999", int'(weights[9][99]), 11);
      check_state("rst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // Single write.
      cycle(0, 1, 3, 7, -1234);
`ifndef HCW_WR_CLAMP_EN
      check("wr_w37", int'(weights[3][7]), -1234);
`endif
      check_state("wr_single");

      // Out-of-range class, then out-of-range clause.
      cycle(0, 1, 12, 0, 99);
      check("bad_cls_err", int'(wr_err), 1);
      check_state("bad_cls");
      cycle(0, 0, 0, 0, 0);
      check_state("bad_cls_after");
      cycle(0, 1, 0, 100, 55);
      check_state("bad_clause");

      // Reload wins over a same-cycle write.
      cycle(0, 1, 5, 5, 500);
      check_state("wr_w55");
      cycle(1, 1, 0, 0, 77);
      check("rl_w55", int'(weights[5][5]), 41);
      check("rl_w00", int'(weights[0][0]), 1);
      check_state("reload");
      cycle(1, 1, 15, 127, 1);
      check_state("reload_bad");

      // Back-to-back writes, same entry and different entries; extreme values.
      cycle(0, 1, 2, 2, 10);
      cycle(0, 1, 2, 2, 20);
      cycle(0, 1, 9, 99, -8192);
      cycle(0, 1, 0, 99, 8191);
      check_state("b2b");

`ifdef HCW_WR_CLAMP_EN
      cycle(0, 1, 1, 1, 200);
      check("clamp_pos", int'(weights[1][1]), 64);
      check("clamp_pos_flag", int'(wr_clamped), 1);
      cycle(0, 1, 1, 2, -100);
      check("clamp_neg", int'(weights[1][2]), -64);
      check_state("clamp_neg");
      cycle(0, 1, 1, 3, 30);
      check("clamp_none", int'(weights[1][3]), 30);
      check("clamp_none_flag", int'(wr_clamped), 0);
      cycle(0, 1, 1, 4, 64);
      check_state("clamp_edge_p");
      cycle(0, 1, 1, 5, -65);
      check_state("clamp_edge_n");
`endif

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         rl = ($urandom_range(0, 99) < 3);
         we = ($urandom_range(0, 99) < 70);
         cls = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NCLS - 1));
         cl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, NCL - 1));
         d   = int'($urandom_range(0, 16383)) - 8192;
         cycle(rl, we, cls, cl, d);
         check_state("rand");
      end

      // Async reset mid-operation, between clock edges.
      cycle(0, 1, 4, 4, 1000);
      cycle(0, 1, 13, 4, 1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      @(negedge clk) rst = 1'b1;
      cycle(0, 0, 0, 0, 0);
      check_state("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
